// File: rtl/avalon_mem_burst_responder.sv
// Avalon-MM burst responder backed by an internal RAM.
// Accepts single and burst reads/writes with per-byte write enables, returns read
// beats after a fixed latency, and latches any protocol violation in proto_err.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a new command, waitrequest low
// WR_BURST | collecting remaining write beats, waitrequest low
// RD_BURST | issuing one read beat per cycle, waitrequest high
module avalon_mem_burst_responder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic                       read,
  input  logic                       write,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  input  logic [DATA_WIDTH-1:0]      writedata,
  input  logic [DATA_WIDTH/8-1:0]    byteenable,
  output logic                       waitrequest,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       readdatavalid,
  output logic                       proto_err
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]      ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_CNT_WIDTH-1:0] BURST_ONE = {{(BURST_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      next_q, next_d;
  logic [BURST_CNT_WIDTH-1:0] remain_q, remain_d;
  logic                       err_q, err_d;

  logic                       wr_en;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0]      wr_word;
  logic                       rd_issue;
  logic [ADDR_WIDTH-1:0]      rd_addr;

  logic [DATA_WIDTH-1:0]                        mem_q [DEPTH];
  logic [READ_LATENCY-1:0]                      vld_q;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]      data_q;

  // waitrequest is combinational so it rises immediately when reset is pulled low
  assign waitrequest   = !reset || (state_q == RD_BURST);
  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign readdata      = data_q[READ_LATENCY-1];
  assign proto_err     = err_q;

  // Next-state, burst bookkeeping, RAM write/read strobes and violation detection
  always_comb begin
    state_d  = state_q;
    next_d   = next_q;
    remain_d = remain_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    wr_addr  = address;
    rd_issue = 1'b0;
    rd_addr  = address;
    case (state_q)
      IDLE: begin
        if (reset && (read || write)) begin
          if (burstcount == '0) begin
            err_d = 1'b1;
          end else if (write) begin
            // read together with write is served as the write
            if (read) err_d = 1'b1;
            wr_en = 1'b1;
            if (burstcount != BURST_ONE) begin
              next_d   = address + ADDR_ONE;
              remain_d = burstcount - BURST_ONE;
              state_d  = WR_BURST;
            end
          end else begin
            rd_issue = 1'b1;
            if (burstcount != BURST_ONE) begin
              next_d   = address + ADDR_ONE;
              remain_d = burstcount - BURST_ONE;
              state_d  = RD_BURST;
            end
          end
        end
      end
      WR_BURST: begin
        if (read) err_d = 1'b1;
        if (write) begin
          wr_en    = 1'b1;
          wr_addr  = next_q;
          next_d   = next_q + ADDR_ONE;
          remain_d = remain_q - BURST_ONE;
          if (remain_q == BURST_ONE) state_d = IDLE;
        end
      end
      RD_BURST: begin
        rd_issue = 1'b1;
        rd_addr  = next_q;
        next_d   = next_q + ADDR_ONE;
        remain_d = remain_q - BURST_ONE;
        if (remain_q == BURST_ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Merge enabled bytes of the write beat into the addressed word
  always_comb begin
    wr_word = mem_q[wr_addr];
    for (int b = 0; b < NBYTES; b++) begin
      if (byteenable[b]) wr_word[b*8 +: 8] = writedata[b*8 +: 8];
    end
  end

  // FSM and burst registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      next_q   <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      next_q   <= next_d;
      remain_q <= remain_d;
      err_q    <= err_d;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_word;
  end

  // Read-latency pipeline; reset drops any beats still in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0]  <= rd_issue;
      data_q[0] <= mem_q[rd_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_avalon_mem_burst_responder.sv
// Randomized self-checking bench for avalon_mem_burst_responder.
// A transaction-level model keeps a RAM image and a queue of (cycle, data) read
// returns; a monitor compares readdatavalid/readdata against it every cycle.
module tb_avalon_mem_burst_responder;

  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int BW  = 4;
  localparam int LAT = 2;
  localparam int NB  = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [BW-1:0] burstcount = '0;
  logic [DW-1:0] writedata = '0;
  logic [NB-1:0] byteenable = '0;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          proto_err;

  avalon_mem_burst_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .burstcount(burstcount), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          edges = 0;
  bit          mon_en = 1'b0;
  logic [63:0] ref_mem [DEPTH];
  bit          ref_err = 1'b0;
  exp_t        exp_q[$];
  logic [63:0] wbuf [16];
  logic [7:0]  bebuf [16];
  int          gap_before [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, edges);
    end
  endtask

  // cycle index = number of rising edges seen so far
  always @(posedge clk) edges++;

  // per-cycle read-return monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == edges) begin
        check("rdv", readdatavalid, 1);
        check("rdata", readdata, exp_q[0].data);
        exp_q.delete(0);
      end else begin
        check("rdv_idle", readdatavalid, 0);
      end
    end
  end

  task automatic idle_inputs();
    read = 1'b0;
    write = 1'b0;
    burstcount = '0;
  endtask

  task automatic ref_write(input int a, input logic [63:0] d, input logic [7:0] be);
    for (int b = 0; b < NB; b++)
      if (be[b]) ref_mem[a % DEPTH][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // write burst of n beats from wbuf/bebuf, with gap_before[] idle cycles
  task automatic do_write(input int addr, input int n, input bit gap_read, input bit rw_both);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap_before[i]; g++) begin
        write = 1'b0;
        read = (i > 0) ? gap_read : 1'b0;
        address = AW'($urandom);
        burstcount = BW'($urandom);
        if (i > 0 && gap_read) ref_err = 1'b1;
        @(negedge clk);
      end
      write = 1'b1;
      read = (i == 0) ? rw_both : 1'b0;
      address = (i == 0) ? AW'(addr) : AW'($urandom);
      burstcount = (i == 0) ? BW'(n) : BW'($urandom);
      writedata = wbuf[i];
      byteenable = bebuf[i];
      check("wr_wait", waitrequest, 0);
      ref_write(addr + i, wbuf[i], bebuf[i]);
      if (i == 0 && rw_both) ref_err = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) gap_before[i] = 0;
  endtask

  // read burst; abort_at>0 pulses reset in that cycle of the burst
  task automatic do_read(input int addr, input int n, input int abort_at);
    int t;
    read = 1'b1;
    write = 1'b0;
    address = AW'(addr);
    burstcount = BW'(n);
    check("rd_accept_wait", waitrequest, 0);
    t = edges;
    for (int i = 0; i < n; i++) exp_q.push_back('{t + LAT + i, ref_mem[(addr + i) % DEPTH]});
    @(negedge clk);
    for (int i = 1; i < n; i++) begin
      if (i == abort_at) begin
        idle_inputs();
        reset = 1'b0;
        for (int k = exp_q.size() - 1; k >= 0; k--)
          if (exp_q[k].cyc > edges) exp_q.delete(k);
        #1;
        check("rst_wait", waitrequest, 1);
        @(negedge clk);
        reset = 1'b1;
        ref_err = 1'b0;
        @(negedge clk);
        check("post_rst_wait", waitrequest, 0);
        check("post_rst_err", proto_err, 0);
        return;
      end
      read = 1'($urandom);
      write = 1'($urandom);
      address = AW'($urandom);
      burstcount = BW'($urandom);
      writedata = {$urandom, $urandom};
      byteenable = NB'($urandom);
      check("rd_wait", waitrequest, 1);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic do_bad_cmd(input bit is_write);
    read = !is_write;
    write = is_write;
    address = AW'($urandom);
    burstcount = '0;
    writedata = {$urandom, $urandom};
    byteenable = '1;
    ref_err = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic fill_rand(input int n, input bit full_be);
    for (int i = 0; i < n; i++) begin
      wbuf[i] = {$urandom, $urandom};
      bebuf[i] = full_be ? 8'hFF : 8'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) gap_before[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_wait", waitrequest, 1);
    check("rst_rdv", readdatavalid, 0);
    check("rst_rdata", readdata, 0);
    check("rst_err", proto_err, 0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_wait", waitrequest, 0);

    // fill the whole RAM so every later read has a defined value
    for (int a = 0; a < DEPTH; a += 15) begin
      fill_rand(15, 1'b1);
      do_write(a, 15, 1'b0, 1'b0);
    end

    // single beat
    wbuf[0] = 64'hDEADBEEF_CAFEF00D; bebuf[0] = 8'hFF;
    do_write('h010, 1, 1'b0, 1'b0);
    do_read('h010, 1, 0);
    repeat (LAT + 1) @(negedge clk);

    // wrapping write burst with a stall after beat 2, then wrapping read
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); bebuf[i] = 8'hFF; end
    gap_before[2] = 1;
    do_write('h3FE, 4, 1'b0, 1'b0);
    check("wrap_model", ref_mem[1], 64'd4);
    do_read('h3FE, 4, 0);
    repeat (LAT + 1) @(negedge clk);

    // byte enables
    wbuf[0] = '0; bebuf[0] = 8'hFF;
    do_write('h020, 1, 1'b0, 1'b0);
    wbuf[0] = '1; bebuf[0] = 8'h0F;
    do_write('h020, 1, 1'b0, 1'b0);
    check("be_model", ref_mem['h020], 64'h00000000_FFFFFFFF);
    do_read('h020, 1, 0);

    // back-to-back reads return without bubbles
    do_read('h100, 2, 0);
    do_read('h200, 1, 0);
    repeat (LAT + 1) @(negedge clk);
    check("err_clean", proto_err, 0);

    // violations
    do_bad_cmd(1'b0);
    do_bad_cmd(1'b1);
    fill_rand(3, 1'b1);
    gap_before[1] = 1;
    do_write('h030, 3, 1'b1, 1'b0);
    repeat (LAT + 1) @(negedge clk);
    check("err_sticky", proto_err, 1);
    do_read('h030, 3, 0);

    // reset in the middle of a read burst, then confirm RAM survived
    do_read('h000, 8, 3);
    check("rst_err_clear", proto_err, 0);
    repeat (LAT + 1) @(negedge clk);
    do_read('h000, 8, 0);
    repeat (LAT + 1) @(negedge clk);

    // randomized traffic
    repeat (150) begin
      int op, n, a;
      op = $urandom_range(0, 9);
      n = $urandom_range(1, 15);
      a = $urandom_range(0, DEPTH - 1);
      if (op < 4) begin
        fill_rand(n, ($urandom_range(0, 1) == 1));
        for (int i = 1; i < n; i++) gap_before[i] = ($urandom_range(0, 3) == 0) ? 1 : 0;
        do_write(a, n, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      end else if (op < 8) begin
        do_read(a, n, 0);
      end else if (op == 8) begin
        do_bad_cmd(1'($urandom));
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      check("proto_err", proto_err, ref_err);
    end

    repeat (LAT + 2) @(negedge clk);
    check("drain", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
